// File: rtl/eval_sched.sv
// eval_sched: round-robin share of one eval core; streams 8-word board, start/finish handshake, score return (optional watchdog: EVAL_SCHED_TIMEOUT_EN)
module eval_sched #(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_i,
   input  logic [N_REQ-1:0]     req_side_i,
   input  logic [N_REQ*32-1:0]  req_data_i,
   output logic [2:0]           board_addr_o,
   output logic [N_REQ-1:0]     grant_o,
   output logic [N_REQ-1:0]     done_o,
   output logic [14:0]          rsp_result_o,
   output logic                 rsp_err_o,
   output logic [31:0]          eval_mem_data_o,
   output logic                 eval_mem_wr_o,
   output logic [2:0]           eval_mem_addr_o,
   output logic                 eval_start_o,
   output logic                 eval_side_o,
   input  logic [14:0]          eval_result_i,
   input  logic                 eval_finished_i
);
   localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE} state_t;
   state_t           state_q;
   logic [N_REQ-1:0] grant_q, done_q, gnt_d;
   logic [RW-1:0]    rr_q, gidx_q, gidx_d;
   logic [RW:0]      sum;
   logic [2:0]       addr_q;
   logic             wr_q, start_q, side_q, side_lat_q, err_q, tmo;
   logic [14:0]      result_q;
   assign board_addr_o    = addr_q;
   assign eval_mem_addr_o = addr_q;
   assign eval_mem_wr_o   = wr_q;
   assign grant_o         = grant_q;
   assign done_o          = done_q;
   assign rsp_result_o    = result_q;
   assign rsp_err_o       = err_q;
   assign eval_start_o    = start_q;
   assign eval_side_o     = side_q;
`ifdef EVAL_SCHED_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 13) ? $clog2(TIMEOUT_CYCLES + 1) : 13;
   logic [CW-1:0] cnt_q;
   assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
   // watchdog: runs only in START/WAIT, so it is zero on every entry to START
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_q <= '0;
      else      cnt_q <= (state_q == S_START || state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
`else
   logic timeout_unused;
   assign timeout_unused = |TIMEOUT_CYCLES;
   assign tmo = 1'b0;
`endif
   // round-robin pick: scan from highest offset down so the lowest offset from rr_q wins
   always_comb begin
      gnt_d  = '0;
      gidx_d = '0;
      sum    = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         sum = {1'b0, rr_q} + (RW+1)'(i);
         if (sum >= (RW+1)'(N_REQ)) sum = sum - (RW+1)'(N_REQ);
         if (req_i[sum[RW-1:0]]) begin
            gnt_d              = '0;
            gnt_d[sum[RW-1:0]] = 1'b1;
            gidx_d             = sum[RW-1:0];
         end
      end
   end
   // granted lane's word passes straight through while writing, zero otherwise
   always_comb begin
      eval_mem_data_o = '0;
      for (int i = 0; i < N_REQ; i++)
         if (wr_q && grant_q[i]) eval_mem_data_o = eval_mem_data_o | req_data_i[i*32 +: 32];
   end
   // transaction FSM with registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         done_q     <= '0;
         rr_q       <= '0;
         gidx_q     <= '0;
         addr_q     <= '0;
         wr_q       <= 1'b0;
         start_q    <= 1'b0;
         side_q     <= 1'b0;
         side_lat_q <= 1'b0;
         err_q      <= 1'b0;
         result_q   <= '0;
      end else begin
         done_q <= '0;
         case (state_q)
            S_IDLE:
               if (|req_i) begin
                  grant_q    <= gnt_d;
                  gidx_q     <= gidx_d;
                  side_lat_q <= req_side_i[gidx_d];
                  wr_q       <= 1'b1;
                  addr_q     <= '0;
                  state_q    <= S_LOAD;
               end
            S_LOAD:
               if (addr_q == 3'd7) begin
                  wr_q    <= 1'b0;
                  addr_q  <= '0;
                  start_q <= 1'b1;
                  side_q  <= side_lat_q;
                  state_q <= S_START;
               end else begin
                  addr_q <= addr_q + 3'd1;
               end
            S_START:
               if (tmo) begin
                  start_q  <= 1'b0;
                  result_q <= '0;
                  err_q    <= 1'b1;
                  done_q   <= grant_q;
                  state_q  <= S_DONE;
               end else if (!eval_finished_i) begin
                  start_q <= 1'b0;
                  state_q <= S_WAIT;
               end
            S_WAIT:
               if (eval_finished_i) begin
                  result_q <= eval_result_i;
                  err_q    <= 1'b0;
                  done_q   <= grant_q;
                  state_q  <= S_DONE;
               end else if (tmo) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
                  done_q   <= grant_q;
                  state_q  <= S_DONE;
               end
            S_DONE: begin
               grant_q <= '0;
               side_q  <= 1'b0;
               rr_q    <= (gidx_q == RW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_eval_sched.sv
// tb_eval_sched: table-driven transactions plus reset/timeout sequences for eval_sched
module tb_eval_sched;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [3:0]   req_i = '0, req_side_i = '0;
   logic [127:0] req_data_i;
   logic [2:0]   board_addr_o, eval_mem_addr_o;
   logic [3:0]   grant_o, done_o;
   logic [14:0]  rsp_result_o, eval_result_i = '0;
   logic         rsp_err_o, eval_mem_wr_o, eval_start_o, eval_side_o;
   logic         eval_finished_i = 1'b0;
   logic [31:0]  eval_mem_data_o;
   int           errors = 0, checks = 0;
   logic [14:0]  last_res = '0;
   typedef struct {
      logic [3:0]  req;
      logic [3:0]  after;
      logic        side;
      int          hold;
      int          waitc;
      logic [14:0] res;
      int          lane;
   } vec_t;
   vec_t tbl[11];
   always #5 clk = ~clk;
   eval_sched #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .req_side_i(req_side_i), .req_data_i(req_data_i),
      .board_addr_o(board_addr_o), .grant_o(grant_o), .done_o(done_o),
      .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o), .eval_mem_data_o(eval_mem_data_o),
      .eval_mem_wr_o(eval_mem_wr_o), .eval_mem_addr_o(eval_mem_addr_o),
      .eval_start_o(eval_start_o), .eval_side_o(eval_side_o),
      .eval_result_i(eval_result_i), .eval_finished_i(eval_finished_i)
   );
   function automatic logic [31:0] lane_word(input int lane, input logic [2:0] k);
      return {16'hC0DE, 8'(lane), 5'd0, k};
   endfunction
   always_comb
      for (int i = 0; i < 4; i++) req_data_i[i*32 +: 32] = lane_word(i, board_addr_o);
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask
   task automatic chk_quiet(input string tag);
      chk({tag, "_grant"}, 32'(grant_o), 0);
      chk({tag, "_done"}, 32'(done_o), 0);
      chk({tag, "_wr"}, 32'(eval_mem_wr_o), 0);
      chk({tag, "_start"}, 32'(eval_start_o), 0);
      chk({tag, "_addr"}, 32'(eval_mem_addr_o), 0);
      chk({tag, "_baddr"}, 32'(board_addr_o), 0);
      chk({tag, "_data"}, eval_mem_data_o, 0);
      chk({tag, "_side"}, 32'(eval_side_o), 0);
   endtask
   task automatic run_txn(input vec_t v);
      logic [3:0] g;
      g = 4'(1 << v.lane);
      @(negedge clk);
      chk("idle_grant", 32'(grant_o), 0);
      chk("idle_done", 32'(done_o), 0);
      req_i           = v.req;
      req_side_i      = {4{v.side}};
      eval_finished_i = (v.hold > 0);
      eval_result_i   = ~v.res;
      @(negedge clk);
      req_i = v.after;
      chk("hold_result", 32'(rsp_result_o), 32'(last_res));
      for (int k = 0; k < 8; k++) begin
         chk("load_grant", 32'(grant_o), 32'(g));
         chk("load_wr", 32'(eval_mem_wr_o), 1);
         chk("load_addr", 32'(eval_mem_addr_o), k);
         chk("load_baddr", 32'(board_addr_o), k);
         chk("load_data", eval_mem_data_o, lane_word(v.lane, 3'(k)));
         chk("load_start", 32'(eval_start_o), 0);
         @(negedge clk);
      end
      for (int s = 0; s <= v.hold; s++) begin
         chk("start_start", 32'(eval_start_o), 1);
         chk("start_side", 32'(eval_side_o), 32'(v.side));
         chk("start_wr", 32'(eval_mem_wr_o), 0);
         chk("start_done", 32'(done_o), 0);
         eval_finished_i = (s < v.hold);
         @(negedge clk);
      end
      for (int w = 0; w < v.waitc; w++) begin
         chk("wait_start", 32'(eval_start_o), 0);
         chk("wait_side", 32'(eval_side_o), 32'(v.side));
         chk("wait_done", 32'(done_o), 0);
         eval_finished_i = (w == v.waitc - 1);
         eval_result_i   = (w == v.waitc - 1) ? v.res : ~v.res;
         @(negedge clk);
      end
      chk("done_pulse", 32'(done_o), 32'(g));
      chk("done_grant", 32'(grant_o), 32'(g));
      chk("done_result", 32'(rsp_result_o), 32'(v.res));
      chk("done_err", 32'(rsp_err_o), 0);
      last_res = v.res;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
      $fatal(1, "watchdog");
   end
   initial begin
      tbl[0]  = '{4'b1111, 4'b1111, 1'b0, 0, 1, 15'h0001, 0};
      tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 0, 2, 15'h1234, 1};
      tbl[2]  = '{4'b1111, 4'b1111, 1'b0, 1, 1, 15'h7FFF, 2};
      tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 0, 3, 15'h4000, 3};
      tbl[4]  = '{4'b1111, 4'b1111, 1'b0, 0, 1, 15'h0000, 0};
      tbl[5]  = '{4'b0100, 4'b0100, 1'b1, 0, 5, 15'h0123, 2};
      tbl[6]  = '{4'b0001, 4'b0001, 1'b0, 3, 2, 15'h2AAA, 0};
      tbl[7]  = '{4'b1010, 4'b1000, 1'b1, 0, 2, 15'h5555, 1};
      tbl[8]  = '{4'b1010, 4'b1010, 1'b0, 0, 1, 15'h0F0F, 3};
      tbl[9]  = '{4'b0011, 4'b0011, 1'b1, 0, 1, 15'h3333, 0};
      tbl[10] = '{4'b0011, 4'b0011, 1'b0, 2, 1, 15'h1111, 1};
      repeat (2) @(negedge clk);
      chk_quiet("rst");
      chk("rst_result", 32'(rsp_result_o), 0);
      chk("rst_err", 32'(rsp_err_o), 0);
      rst = 1'b1;
      @(negedge clk);
      eval_finished_i = 1'b1;
      @(negedge clk);
      chk_quiet("idle_fin");
      req_i      = 4'b0010;
      req_side_i = 4'b1111;
      @(negedge clk);
      chk("mid_grant", 32'(grant_o), 32'h2);
      chk("mid_addr0", 32'(eval_mem_addr_o), 0);
      repeat (4) @(negedge clk);
      chk("mid_addr4", 32'(eval_mem_addr_o), 4);
      chk("mid_data4", eval_mem_data_o, lane_word(1, 3'd4));
      rst = 1'b0;
      #1;
      chk_quiet("async_rst");
      @(negedge clk);
      rst   = 1'b1;
      req_i = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_quiet("post_rst");
      end
      for (int t = 0; t < 11; t++) run_txn(tbl[t]);
`ifdef EVAL_SCHED_TIMEOUT_EN
      @(negedge clk);
      req_i           = 4'b1100;
      req_side_i      = '0;
      eval_finished_i = 1'b0;
      @(negedge clk);
      chk("tmo_grant", 32'(grant_o), 32'h4);
      repeat (8) @(negedge clk);
      for (int c = 0; c < 16; c++) begin
         chk("tmo_nodone", 32'(done_o), 0);
         chk("tmo_start", 32'(eval_start_o), (c == 0) ? 1 : 0);
         @(negedge clk);
      end
      chk("tmo_done", 32'(done_o), 32'h4);
      chk("tmo_err", 32'(rsp_err_o), 1);
      chk("tmo_result", 32'(rsp_result_o), 0);
      chk("tmo_start_off", 32'(eval_start_o), 0);
      @(negedge clk);
      @(negedge clk);
      chk("tmo_next_grant", 32'(grant_o), 32'h8);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
